logic_unit_serial: RTL and testbench

LOGIC_UNIT_SERIAL -- requirements
Module: logic_unit_serial

---
 rtl/logic_unit_serial.sv | 152 +++++++++++++++
 tb/tb_logic_unit_serial.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_serial.sv
// Bitwise logic unit that evaluates a 16-bit operation four bits per cycle.
// Optional zero/parity outputs are built when LOGIC_UNIT_FLAGS_EN is defined.
module logic_unit_serial #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_err,
`ifdef LOGIC_UNIT_FLAGS_EN
  output logic             out_zero,
  output logic             out_parity,
`endif
  output logic [1:0]       o_dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both 1; valid, once raised, holds its payload stable until that edge.

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = $clog2(NSLICE);
  localparam logic [CW-1:0] LAST_SLICE = CW'(NSLICE - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_result;
  logic [CW-1:0]    r_cnt;
  logic             r_err;
  logic [SLICE-1:0] w_sa;
  logic [SLICE-1:0] w_sb;
  logic [SLICE-1:0] w_slice;
  logic [WIDTH-1:0] w_result_next;
  logic             w_last;
`ifdef LOGIC_UNIT_FLAGS_EN
  logic             r_zero;
  logic             r_parity;
`endif

  function automatic logic [SLICE-1:0] op_eval(input logic [2:0] op,
                                                input logic [SLICE-1:0] a,
                                                input logic [SLICE-1:0] b);
    logic [SLICE-1:0] r;
    case (op)
      3'd0:    r = a & b;
      3'd1:    r = a | b;
      3'd2:    r = a ^ b;
      3'd3:    r = ~a;
      3'd4:    r = ~(a & b);
      3'd5:    r = ~(a | b);
      3'd6:    r = ~(a ^ b);
      default: r = '0;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_next = S_BUSY;
      S_BUSY:  if (r_cnt == LAST_SLICE) w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_sa          = r_a[r_cnt*SLICE +: SLICE];
    w_sb          = r_b[r_cnt*SLICE +: SLICE];
    w_slice       = op_eval(r_op, w_sa, w_sb);
    w_result_next = r_result;
    w_result_next[r_cnt*SLICE +: SLICE] = w_slice;
    w_last        = (r_state == S_BUSY) && (r_cnt == LAST_SLICE);
  end

  // Operands are latched at capture so input changes cannot reach the op in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_cnt    <= '0;
      r_err    <= 1'b0;
`ifdef LOGIC_UNIT_FLAGS_EN
      r_zero   <= 1'b0;
      r_parity <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_op     <= in_op;
            r_a      <= in_a;
            r_b      <= in_b;
            r_result <= '0;
            r_cnt    <= '0;
            r_err    <= 1'b0;
`ifdef LOGIC_UNIT_FLAGS_EN
            r_zero   <= 1'b0;
            r_parity <= 1'b0;
`endif
          end
        end
        S_BUSY: begin
          r_result <= w_result_next;
          r_cnt    <= r_cnt + CW'(1);
          if (w_last) begin
            r_err    <= (r_op == 3'd7);
`ifdef LOGIC_UNIT_FLAGS_EN
            r_zero   <= (w_result_next == '0);
            r_parity <= ^w_result_next;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready    = (r_state == S_IDLE);
  assign out_valid   = (r_state == S_DONE);
  assign out_result  = r_result;
  assign out_err     = r_err;
  assign o_dbg_state = r_state;
`ifdef LOGIC_UNIT_FLAGS_EN
  assign out_zero    = r_zero;
  assign out_parity  = r_parity;
`endif

endmodule

// File: tb/tb_logic_unit_serial.sv
// Directed bench for logic_unit_serial: vector table plus hold, reset and
// operand-change sequences.
module tb_logic_unit_serial;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic        out_err;
  logic [1:0]  o_dbg_state;
`ifdef LOGIC_UNIT_FLAGS_EN
  logic        out_zero;
  logic        out_parity;
`endif

  int errors = 0;
  int checks = 0;

  logic [15:0] exp_q[$];

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic        err;
  } vec_t;

  vec_t vecs[9];

  logic_unit_serial dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_err    (out_err),
`ifdef LOGIC_UNIT_FLAGS_EN
    .out_zero   (out_zero),
    .out_parity (out_parity),
`endif
    .o_dbg_state(o_dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver: present an op and return #1 after its capture edge
  task automatic start_op(input string name, input logic [2:0] op,
                          input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    chk({name, " in_ready before capture"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int edges);
    edges = 0;
    while (!out_valid && edges < 20) begin
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  task automatic check_result(input string name, input logic [15:0] res, input logic err);
    chk({name, " out_valid"}, 32'(out_valid), 32'd1);
    chk({name, " out_result"}, 32'(out_result), 32'(res));
    chk({name, " out_err"}, 32'(out_err), 32'(err));
`ifdef LOGIC_UNIT_FLAGS_EN
    chk({name, " out_zero"}, 32'(out_zero), 32'(res == 16'h0000));
    chk({name, " out_parity"}, 32'(out_parity), 32'(^res));
`endif
  endtask

  initial begin
    int edges;
    logic seen;
    logic [15:0] exp;

    vecs[0] = '{3'd0, 16'hF0F0, 16'hFF00, 16'hF000, 1'b0};
    vecs[1] = '{3'd0, 16'hA5C3, 16'h0FF0, 16'h05C0, 1'b0};
    vecs[2] = '{3'd1, 16'hA5C3, 16'h0FF0, 16'hAFF3, 1'b0};
    vecs[3] = '{3'd2, 16'hA5C3, 16'h0FF0, 16'hAA33, 1'b0};
    vecs[4] = '{3'd3, 16'hA5C3, 16'h0FF0, 16'h5A3C, 1'b0};
    vecs[5] = '{3'd4, 16'hA5C3, 16'h0FF0, 16'hFA3F, 1'b0};
    vecs[6] = '{3'd5, 16'hA5C3, 16'h0FF0, 16'h500C, 1'b0};
    vecs[7] = '{3'd6, 16'hA5C3, 16'h0FF0, 16'h55CC, 1'b0};
    vecs[8] = '{3'd7, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b1};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_op     = 3'd0;
    in_a      = 16'h0;
    in_b      = 16'h0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset out_result", 32'(out_result), 32'd0);
    chk("reset out_err", 32'(out_err), 32'd0);
    chk("reset state", 32'(o_dbg_state), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // vector table, out_ready held high
    for (int i = 0; i < 9; i++) begin
      string nm;
      nm = $sformatf("vec%0d op%0d", i, vecs[i].op);
      start_op(nm, vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done(edges);
      chk({nm, " latency"}, 32'(edges), 32'd4);
      check_result(nm, vecs[i].res, vecs[i].err);
      @(posedge clk);
      #1;
      chk({nm, " out_valid cleared"}, 32'(out_valid), 32'd0);
      chk({nm, " in_ready back"}, 32'(in_ready), 32'd1);
    end

    // hold in DONE while inputs toggle
    out_ready = 1'b0;
    exp_q.push_back(16'h05C0);
    start_op("hold", 3'd0, 16'hA5C3, 16'h0FF0);
    wait_done(edges);
    chk("hold latency", 32'(edges), 32'd4);
    exp = exp_q.pop_front();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'($urandom_range(0, 1));
      in_op    = 3'($urandom_range(0, 7));
      in_a     = 16'($urandom_range(0, 65535));
      in_b     = 16'($urandom_range(0, 65535));
      @(posedge clk);
      #1;
      chk($sformatf("hold%0d out_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("hold%0d out_result", i), 32'(out_result), 32'(exp));
      chk($sformatf("hold%0d out_err", i), 32'(out_err), 32'd0);
      chk($sformatf("hold%0d in_ready", i), 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("hold release out_valid", 32'(out_valid), 32'd0);
    chk("hold release in_ready", 32'(in_ready), 32'd1);
    repeat (6) @(posedge clk);
    #1;
    chk("hold no second capture", 32'(o_dbg_state), 32'd0);

    // reset mid-BUSY discards the operation
    start_op("rst", 3'd1, 16'h1111, 16'h2222);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst async state", 32'(o_dbg_state), 32'd0);
    chk("rst async in_ready", 32'(in_ready), 32'd1);
    chk("rst async out_result", 32'(out_result), 32'd0);
    chk("rst async out_err", 32'(out_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    chk("rst discarded op", 32'(seen), 32'd0);
    start_op("rst xor", 3'd2, 16'h1234, 16'h1234);
    wait_done(edges);
    chk("rst xor latency", 32'(edges), 32'd4);
    check_result("rst xor", 16'h0000, 1'b0);
    @(posedge clk);
    #1;

    // operands change right after capture
    start_op("chg", 3'd1, 16'h00FF, 16'h0000);
    in_a  = 16'hFF00;
    in_b  = 16'hFFFF;
    in_op = 3'd7;
    wait_done(edges);
    chk("chg latency", 32'(edges), 32'd4);
    check_result("chg", 16'h00FF, 1'b0);
    @(posedge clk);
    #1;
    chk("chg in_ready back", 32'(in_ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
